// File: rtl/gpio_ctrl_unit.sv
// gpio_ctrl_unit: GPIO command decoder and register file sitting between the
// MicroBlaze GPIO bus and the convolution datapath/FSM. Commands are decoded
// on the rising edge of the GPIO valid bit; the frame lifecycle is tracked in
// an IDLE/LOAD/RUN/OUT state machine with abort, status readback and a sticky
// illegal-command flag.
module gpio_ctrl_unit #(
  parameter int GPIO_W    = 32,
  parameter int OPC_W     = 3,
  parameter int DATA_W    = 24,
  parameter int MCU_W     = 13,
  parameter int LEN_W     = 10,
  parameter int KNL_WORDS = 3
) (
  input  logic                       i_CLK,
  input  logic                       i_rst,
  input  logic [GPIO_W-1:0]          i_gpio_data,
  input  logic [MCU_W-1:0]           i_mcu_data,
  input  logic                       i_eop,
  output logic [GPIO_W-1:0]          o_gpio_data,
  output logic [DATA_W-1:0]          o_knl_data,
  output logic [$clog2(KNL_WORDS):0] o_knl_idx,
  output logic                       o_knl_valid,
  output logic [DATA_W-1:0]          o_pix_data,
  output logic                       o_pix_valid,
  output logic [LEN_W-1:0]           o_img_len,
  output logic                       o_load,
  output logic                       o_run,
  output logic                       o_req_valid,
  output logic                       o_eop_mcu,
  output logic [1:0]                 o_state,
  output logic                       o_err
);

  localparam int VLD_BIT = GPIO_W - OPC_W - 1;
  localparam int IDX_W   = $clog2(KNL_WORDS) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KNL_WORDS - 1);

  localparam logic [OPC_W-1:0] OP_KNL  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SIZE = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_IMG  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_REQ  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_RUN  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_STAT = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_ABRT = OPC_W'(6);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  logic [GPIO_W-1:0] r_gpio_p0;
  logic              r_vld_p1;
  state_t            r_state;
  logic [IDX_W-1:0]  r_knl_idx;
  logic              r_knl_full;
  logic              r_hold;

  logic              w_stb;
  logic              w_legal;
  logic              w_unused;
  logic [OPC_W-1:0]  w_opc;
  logic [DATA_W-1:0] w_pay;

  assign w_opc    = r_gpio_p0[GPIO_W-1 -: OPC_W];
  assign w_pay    = r_gpio_p0[DATA_W-1:0];
  assign w_stb    = r_gpio_p0[VLD_BIT] & ~r_vld_p1;
  assign o_state  = r_state;
  // Reserved field bits between the valid bit and the payload carry no meaning.
  assign w_unused = ^r_gpio_p0;

  // Stage 0/1: register the GPIO word and keep the previous valid for edge detection
  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      r_gpio_p0 <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_gpio_p0 <= i_gpio_data;
      r_vld_p1  <= r_gpio_p0[VLD_BIT];
    end
  end

  // Decide whether the captured opcode is allowed in the current state
  always_comb begin
    w_legal = 1'b0;
    case (w_opc)
      OP_KNL:  w_legal = (r_state == ST_IDLE) || (r_state == ST_LOAD);
      OP_SIZE: w_legal = (r_state == ST_IDLE);
      OP_IMG:  w_legal = (r_state != ST_RUN) && (o_img_len != '0);
      OP_REQ:  w_legal = (r_state == ST_OUT);
      OP_RUN:  w_legal = (r_state == ST_LOAD) && r_knl_full;
      OP_STAT: w_legal = 1'b1;
      OP_ABRT: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // Stage 2: execute strobed commands, advance the frame FSM, drive all outputs
  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_knl_idx   <= '0;
      r_knl_full  <= 1'b0;
      r_hold      <= 1'b0;
      o_gpio_data <= '0;
      o_knl_data  <= '0;
      o_knl_idx   <= '0;
      o_knl_valid <= 1'b0;
      o_pix_data  <= '0;
      o_pix_valid <= 1'b0;
      o_img_len   <= '0;
      o_load      <= 1'b0;
      o_run       <= 1'b0;
      o_req_valid <= 1'b0;
      o_eop_mcu   <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_knl_valid <= 1'b0;
      o_pix_valid <= 1'b0;
      o_load      <= 1'b0;
      o_req_valid <= 1'b0;

      // Result word streams through unless a status snapshot is being held.
      if (!r_hold) o_gpio_data <= GPIO_W'(i_mcu_data);

      // End of processing; an ABORT strobe in the same cycle overrides this below.
      if ((r_state == ST_RUN) && i_eop) begin
        r_state   <= ST_OUT;
        o_run     <= 1'b0;
        o_eop_mcu <= 1'b1;
      end

      if (w_stb) begin
        if (w_opc != OP_STAT) begin
          r_hold      <= 1'b0;
          o_gpio_data <= GPIO_W'(i_mcu_data);
        end
        if (!w_legal) begin
          o_err <= 1'b1;
        end else begin
          case (w_opc)
            OP_KNL: begin
              o_knl_data  <= w_pay;
              o_knl_idx   <= r_knl_idx;
              o_knl_valid <= 1'b1;
              if (r_knl_idx == IDX_LAST) begin
                r_knl_idx  <= '0;
                r_knl_full <= 1'b1;
              end else begin
                r_knl_idx <= r_knl_idx + 1'b1;
              end
            end
            OP_SIZE: o_img_len <= w_pay[LEN_W-1:0];
            OP_IMG: begin
              o_pix_data  <= w_pay;
              o_pix_valid <= 1'b1;
              // First image word of a frame (fresh or back-to-back) starts it.
              if (r_state != ST_LOAD) begin
                o_load    <= 1'b1;
                r_state   <= ST_LOAD;
                o_eop_mcu <= 1'b0;
              end
            end
            OP_REQ: o_req_valid <= 1'b1;
            OP_RUN: begin
              r_state <= ST_RUN;
              o_run   <= 1'b1;
            end
            OP_STAT: begin
              // Snapshot reflects the state before any same-cycle i_eop transition.
              o_gpio_data <= GPIO_W'({r_knl_full, o_err, o_eop_mcu, o_run, r_state});
              r_hold      <= 1'b1;
            end
            OP_ABRT: begin
              r_state    <= ST_IDLE;
              o_run      <= 1'b0;
              o_eop_mcu  <= 1'b0;
              o_err      <= 1'b0;
              r_knl_idx  <= '0;
              r_knl_full <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_ctrl_unit.sv
// tb_gpio_ctrl_unit: directed frame scenarios followed by randomized command
// traffic, compared every cycle against a command-level behavioural model.
module tb_gpio_ctrl_unit;

  localparam int KW = 3;
  localparam int IDLE = 0, LOAD = 1, RUN = 2, OUT = 3;
  // Bit s set when the opcode is allowed in state s (opcode 7 never).
  localparam bit [3:0] LEGAL [8] = '{4'b0011, 4'b0001, 4'b1011, 4'b1000,
                                     4'b0010, 4'b1111, 4'b1111, 4'b0000};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] gpio  = '0;
  logic [12:0] mcu   = '0;
  logic        eop   = 1'b0;

  logic [31:0] d_gpio;
  logic [23:0] d_knl, d_pix;
  logic [2:0]  d_idx;
  logic        d_knl_v, d_pix_v, d_load, d_run, d_req, d_eopm, d_err;
  logic [9:0]  d_len;
  logic [1:0]  d_state;

  gpio_ctrl_unit #(.GPIO_W(32), .OPC_W(3), .DATA_W(24), .MCU_W(13),
                   .LEN_W(10), .KNL_WORDS(KW)) dut (
    .i_CLK(clk), .i_rst(rst_n), .i_gpio_data(gpio), .i_mcu_data(mcu),
    .i_eop(eop), .o_gpio_data(d_gpio), .o_knl_data(d_knl), .o_knl_idx(d_idx),
    .o_knl_valid(d_knl_v), .o_pix_data(d_pix), .o_pix_valid(d_pix_v),
    .o_img_len(d_len), .o_load(d_load), .o_run(d_run), .o_req_valid(d_req),
    .o_eop_mcu(d_eopm), .o_state(d_state), .o_err(d_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_state, m_kcount, op, old_st;
  bit          m_run, m_eopm, m_err, m_hold, ok, abort_now, stat_now, full_b;
  bit          m_knl_v, m_pix_v, m_load, m_req, pend, prev_v;
  logic [23:0] m_knl, m_pix, pay;
  logic [2:0]  m_idx;
  logic [9:0]  m_len;
  logic [31:0] m_gpio, pend_word;

  task automatic m_reset();
    m_state = IDLE; m_kcount = 0; m_run = 1'b0; m_eopm = 1'b0; m_err = 1'b0;
    m_hold = 1'b0; m_knl_v = 1'b0; m_pix_v = 1'b0; m_load = 1'b0; m_req = 1'b0;
    pend = 1'b0; prev_v = 1'b0; m_knl = '0; m_pix = '0; m_idx = '0; m_len = '0;
    m_gpio = '0; pend_word = '0;
  endtask

  // A valid edge seen on the pins at one clock takes effect on the next clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      old_st = m_state; abort_now = 1'b0; stat_now = 1'b0;
      m_knl_v = 1'b0; m_pix_v = 1'b0; m_load = 1'b0; m_req = 1'b0;
      if (pend) begin
        op  = int'(pend_word[31:29]);
        pay = pend_word[23:0];
        ok  = LEGAL[op][m_state];
        if (op == 2 && m_len == 10'd0) ok = 1'b0;
        if (op == 4 && m_kcount < KW) ok = 1'b0;
        if (op != 5) m_hold = 1'b0;
        if (!ok) m_err = 1'b1;
        else begin
          case (op)
            0: begin m_knl = pay; m_idx = 3'(m_kcount % KW); m_kcount++; m_knl_v = 1'b1; end
            1: m_len = pay[9:0];
            2: begin
              m_pix = pay; m_pix_v = 1'b1;
              if (m_state != LOAD) begin m_load = 1'b1; m_state = LOAD; m_eopm = 1'b0; end
            end
            3: m_req = 1'b1;
            4: begin m_state = RUN; m_run = 1'b1; end
            5: begin
              stat_now = 1'b1; m_hold = 1'b1; full_b = (m_kcount >= KW);
              m_gpio = {26'd0, full_b, m_err, m_eopm, m_run, 2'(m_state)};
            end
            6: begin
              abort_now = 1'b1; m_state = IDLE; m_run = 1'b0; m_eopm = 1'b0;
              m_err = 1'b0; m_kcount = 0;
            end
            default: ;
          endcase
        end
      end
      if (old_st == RUN && eop && !abort_now) begin m_state = OUT; m_run = 1'b0; m_eopm = 1'b1; end
      if (!stat_now && !m_hold) m_gpio = {19'd0, mcu};
      pend      = gpio[28] && !prev_v;
      pend_word = gpio;
      prev_v    = gpio[28];
    end
  end

  // Single compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    chk("gpio_data", 64'(d_gpio), 64'(m_gpio));
    chk("knl_data",  64'(d_knl),  64'(m_knl));
    chk("knl_idx",   64'(d_idx),  64'(m_idx));
    chk("knl_valid", 64'(d_knl_v), 64'(m_knl_v));
    chk("pix_data",  64'(d_pix),  64'(m_pix));
    chk("pix_valid", 64'(d_pix_v), 64'(m_pix_v));
    chk("img_len",   64'(d_len),  64'(m_len));
    chk("load",      64'(d_load), 64'(m_load));
    chk("run",       64'(d_run),  64'(m_run));
    chk("req_valid", 64'(d_req),  64'(m_req));
    chk("eop_mcu",   64'(d_eopm), 64'(m_eopm));
    chk("state",     64'(d_state), 64'(m_state));
    chk("err",       64'(d_err),  64'(m_err));
  end

  int c_knl = 0, c_pix = 0, c_load = 0, c_req = 0;
  always @(negedge clk) begin
    if (d_knl_v) c_knl++;
    if (d_pix_v) c_pix++;
    if (d_load)  c_load++;
    if (d_req)   c_req++;
  end

  // ---------------- stimulus ----------------
  bit rand_eop = 1'b0;

  task automatic tick();
    @(negedge clk);
    mcu = 13'($urandom);
    if (rand_eop) eop = ($urandom_range(0, 3) == 0);
  endtask

  task automatic set_cmd(input int opc, input int pl);
    logic [31:0] w;
    w = '0; w[31:29] = opc[2:0]; w[28] = 1'b1; w[23:0] = pl[23:0];
    gpio = w;
  endtask

  task automatic send(input int opc, input int pl, input int hold, input int gap);
    set_cmd(opc, pl);
    repeat (hold) tick();
    gpio[28] = 1'b0;
    repeat (gap) tick();
  endtask

  int pb, lb, rb;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_state", 64'(d_state), 64'(0));
    chk("rst_gpio",  64'(d_gpio),  64'(0));
    chk("rst_err",   64'(d_err),   64'(0));
    rst_n = 1'b1;
    tick(); tick();

    // Kernel load: each pulse lands two cycles after its valid edge.
    for (int i = 0; i < 3; i++) begin
      set_cmd(0, i + 1);
      tick();
      chk("knl_v_early", 64'(d_knl_v), 64'(0));
      gpio[28] = 1'b0;
      tick();
      chk("knl_v_lat",  64'(d_knl_v), 64'(1));
      chk("knl_idx_l",  64'(d_idx),   64'(i));
      chk("knl_data_l", 64'(d_knl),   64'(i + 1));
      tick();
    end
    send(5, 0, 1, 2);
    chk("status_full", 64'(d_gpio[5:0]), 64'(6'b100000));

    send(1, 'h0C8, 1, 2);
    chk("img_len_200", 64'(d_len), 64'(200));
    pb = c_pix; lb = c_load;
    send(2, 'hABCDEF, 10, 2);
    chk("one_pix", 64'(c_pix - pb), 64'(1));
    chk("one_load", 64'(c_load - lb), 64'(1));
    chk("state_load", 64'(d_state), 64'(1));
    chk("pix_data_l", 64'(d_pix), 64'(24'hABCDEF));

    send(4, 0, 1, 2);
    chk("run_on", 64'(d_run), 64'(1));
    chk("state_run", 64'(d_state), 64'(2));
    eop = 1'b1; repeat (5) tick(); eop = 1'b0; tick();
    chk("state_out", 64'(d_state), 64'(3));
    chk("eop_mcu_on", 64'(d_eopm), 64'(1));
    chk("run_off", 64'(d_run), 64'(0));
    rb = c_req;
    repeat (3) send(3, 0, 1, 1);
    tick();
    chk("three_req", 64'(c_req - rb), 64'(3));

    // Back-to-back frame from OUT, then abort.
    lb = c_load;
    send(2, 'h123456, 1, 2);
    chk("b2b_load", 64'(c_load - lb), 64'(1));
    chk("b2b_eop_clr", 64'(d_eopm), 64'(0));
    chk("b2b_state", 64'(d_state), 64'(1));
    send(6, 0, 1, 2);
    chk("abort_idle", 64'(d_state), 64'(0));
    chk("abort_err", 64'(d_err), 64'(0));
    chk("abort_len", 64'(d_len), 64'(200));

    // RUN with an incomplete kernel.
    send(0, 'h11, 1, 2); send(0, 'h22, 1, 2); send(2, 'h33, 1, 2); send(4, 0, 1, 2);
    chk("run_nofull_err", 64'(d_err), 64'(1));
    chk("run_nofull_st", 64'(d_state), 64'(1));
    send(5, 0, 1, 2);
    chk("status_err", 64'(d_gpio[5:0]), 64'(6'b010001));

    // IMG while running.
    send(6, 0, 1, 2);
    send(0, 'h44, 1, 2); send(0, 'h55, 1, 2); send(0, 'h66, 1, 2);
    send(2, 'h77, 1, 2); send(4, 0, 1, 2);
    chk("run_again", 64'(d_state), 64'(2));
    send(2, 'h88, 1, 2);
    chk("img_in_run_err", 64'(d_err), 64'(1));
    chk("img_in_run_st", 64'(d_state), 64'(2));

    // Asynchronous reset between clock edges.
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("arst_state", 64'(d_state), 64'(0));
    chk("arst_run", 64'(d_run), 64'(0));
    chk("arst_err", 64'(d_err), 64'(0));
    chk("arst_len", 64'(d_len), 64'(0));
    chk("arst_knl", 64'(d_knl), 64'(0));
    chk("arst_gpio", 64'(d_gpio), 64'(0));
    @(negedge clk); rst_n = 1'b1; tick();

    // IMG with zero image length, then opcode 7.
    pb = c_pix;
    send(2, 1, 1, 2);
    chk("len0_err", 64'(d_err), 64'(1));
    chk("len0_nopix", 64'(c_pix - pb), 64'(0));
    chk("len0_state", 64'(d_state), 64'(0));
    send(6, 0, 1, 2);
    send(7, 0, 1, 2);
    chk("op7_err", 64'(d_err), 64'(1));

    // Randomized traffic.
    send(6, 0, 1, 2);
    rand_eop = 1'b1;
    for (int k = 0; k < 600; k++) begin
      int r, o, p;
      r = int'($urandom_range(0, 99));
      o = r < 20 ? 0 : r < 30 ? 1 : r < 50 ? 2 : r < 62 ? 3 : r < 75 ? 4 :
          r < 88 ? 5 : r < 95 ? 6 : 7;
      p = int'($urandom & 32'h00FF_FFFF);
      if (o == 1 && $urandom_range(0, 4) == 0) p = p & 'hFFFC00;
      send(o, p, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    end
    rand_eop = 1'b0; eop = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
